// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle driven by vga_timing_gen and observed by the pixel generators.
interface vga_timing_gen_if;
    logic [15:0] Hcount;
    logic [15:0] Vcount;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic        pix_tick;
    logic        frame_start;

    modport master (
        output Hcount, Vcount, hsync, vsync, video_on, pix_tick, frame_start
    );

    modport slave (
        input  Hcount, Vcount, hsync, vsync, video_on, pix_tick, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator: clock divider to pixel rate,
// Hcount/Vcount raster counters and registered sync/active-video decodes.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 56,
    parameter int unsigned H_SYNC   = 120,
    parameter int unsigned H_BP     = 64,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 37,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 23,
    parameter bit          HS_POL   = 1'b1,
    parameter bit          VS_POL   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    vga_timing_gen_if.master vga
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
    localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0]  div_q, div_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [15:0] vcnt_q, vcnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        video_q, video_d;
    logic        frame_q, frame_d;
    logic        tick;
    logic        h_wrap;
    logic        v_wrap;

    // Next-state: divider, raster counters, and sync/video decoded from the next counts
    // so the registered outputs always line up with the counts presented alongside them.
    always_comb begin
        tick    = (div_q == DIV_LAST);
        h_wrap  = (hcnt_q == H_LAST);
        v_wrap  = (vcnt_q == V_LAST);
        div_d   = tick ? '0 : div_q + 4'd1;
        hcnt_d  = hcnt_q;
        vcnt_d  = vcnt_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        video_d = video_q;
        frame_d = tick && h_wrap && v_wrap;
        if (tick) begin
            hcnt_d = h_wrap ? '0 : hcnt_q + 16'd1;
            if (h_wrap) begin
                vcnt_d = v_wrap ? '0 : vcnt_q + 16'd1;
            end
            hsync_d = ((hcnt_d >= HS_BEG) && (hcnt_d < HS_END)) ? HS_POL : ~HS_POL;
            vsync_d = ((vcnt_d >= VS_BEG) && (vcnt_d < VS_END)) ? VS_POL : ~VS_POL;
            video_d = (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
        end
    end

    // State registers; reset restarts the raster at (0,0) with syncs inactive.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q   <= '0;
            hcnt_q  <= '0;
            vcnt_q  <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            video_q <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            hcnt_q  <= hcnt_d;
            vcnt_q  <= vcnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            video_q <= video_d;
            frame_q <= frame_d;
        end
    end

    assign vga.Hcount      = hcnt_q;
    assign vga.Vcount      = vcnt_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.video_on    = video_q;
    assign vga.pix_tick    = tick;
    assign vga.frame_start = frame_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: default 800x600 timing, CLK_DIV=1 variant and a
// small-raster variant (inverted hsync) checked against an arithmetic raster model.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [15:0] h;
        logic [15:0] v;
        logic        hs;
        logic        vs;
        logic        vo;
        logic        pt;
        logic        fs;
    } obs_t;

    typedef struct packed {
        longint div;
        longint ha;
        longint hfp;
        longint hsw;
        longint hbp;
        longint va;
        longint vfp;
        longint vsw;
        longint vbp;
        bit     hpol;
        bit     vpol;
    } tcfg_t;

    typedef struct {
        int     sel;
        longint n;
        obs_t   exp;
    } vec_t;

    localparam tcfg_t CFG_A = '{2, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};
    localparam tcfg_t CFG_1 = '{1, 800, 56, 120, 64, 600, 37, 6, 23, 1'b1, 1'b1};
    localparam tcfg_t CFG_S = '{3, 20, 3, 4, 5, 12, 2, 3, 4, 1'b0, 1'b1};

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_s = 1'b1;
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b0;
    longint n_a;
    longint n_s;

    always #5 clk = ~clk;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if if1 ();
    vga_timing_gen_if ifs ();

    vga_timing_gen u_dut_a (.clk(clk), .reset(rst_a), .vga(ifa));

    vga_timing_gen #(.CLK_DIV(1)) u_dut_1 (.clk(clk), .reset(rst_a), .vga(if1));

    vga_timing_gen #(
        .CLK_DIV(3), .H_ACTIVE(20), .H_FP(3), .H_SYNC(4), .H_BP(5),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(4), .HS_POL(1'b0), .VS_POL(1'b1)
    ) u_dut_s (.clk(clk), .reset(rst_s), .vga(ifs));

    obs_t obs_a, obs_1, obs_s;
    assign obs_a = {ifa.Hcount, ifa.Vcount, ifa.hsync, ifa.vsync, ifa.video_on, ifa.pix_tick, ifa.frame_start};
    assign obs_1 = {if1.Hcount, if1.Vcount, if1.hsync, if1.vsync, if1.video_on, if1.pix_tick, if1.frame_start};
    assign obs_s = {ifs.Hcount, ifs.Vcount, ifs.hsync, ifs.vsync, ifs.video_on, ifs.pix_tick, ifs.frame_start};

    // Clocks elapsed since each reset was last released.
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) n_a <= 0;
        else       n_a <= n_a + 1;
    end

    always @(posedge clk or posedge rst_s) begin
        if (rst_s) n_s <= 0;
        else       n_s <= n_s + 1;
    end

    // Raster position follows from the number of pixel ticks since reset.
    function automatic obs_t model(tcfg_t c, longint n);
        longint ht, vt, ticks, pos, h, v;
        obs_t o;
        ht    = c.ha + c.hfp + c.hsw + c.hbp;
        vt    = c.va + c.vfp + c.vsw + c.vbp;
        ticks = n / c.div;
        pos   = ticks % (ht * vt);
        h     = pos % ht;
        v     = pos / ht;
        o.h   = h[15:0];
        o.v   = v[15:0];
        o.pt  = ((n % c.div) == c.div - 1);
        if (ticks == 0) begin
            o.hs = ~c.hpol;
            o.vs = ~c.vpol;
            o.vo = 1'b0;
        end else begin
            o.hs = (h >= c.ha + c.hfp && h < c.ha + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
            o.vs = (v >= c.va + c.vfp && v < c.va + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
            o.vo = (h < c.ha) && (v < c.va);
        end
        o.fs = (n > 0) && (n % c.div == 0) && (pos == 0);
        return o;
    endfunction

    function automatic obs_t mk(int h, int v, bit hs, bit vs, bit vo, bit pt, bit fs);
        obs_t o;
        o.h = 16'(h); o.v = 16'(v);
        o.hs = hs; o.vs = vs; o.vo = vo; o.pt = pt; o.fs = fs;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("H=%0d V=%0d hs=%b vs=%b vo=%b pt=%b fs=%b",
                         o.h, o.v, o.hs, o.vs, o.vo, o.pt, o.fs);
    endfunction

    task automatic check(string nm, obs_t act, obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got {%s} expected {%s}", nm, $time, fmt(act), fmt(exp));
        end
    endtask

    task automatic chk_int(string nm, longint act, longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Every DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("run_a", obs_a, model(CFG_A, n_a));
            check("run_1", obs_1, model(CFG_1, n_a));
            check("run_s", obs_s, model(CFG_S, n_s));
        end
    end

    task automatic pulse_reset(bit do_a, bit do_s, int unsigned hold);
        @(negedge clk);
        #2;
        if (do_a) rst_a = 1'b1;
        if (do_s) rst_s = 1'b1;
        repeat (hold) @(negedge clk);
        #2;
        rst_a = 1'b0;
        rst_s = 1'b0;
    endtask

    initial begin
        vec_t vt[$];
        bit   ok;
        int   per, vs_cnt, hs_cnt, vo_cnt, fs_cnt, t_a, t_1;
        bit   fs_after;

        vt.push_back('{0, 0,     mk(0,    0,  0, 0, 0, 0, 0)});
        vt.push_back('{1, 0,     mk(0,    0,  0, 0, 0, 1, 0)});
        vt.push_back('{0, 1,     mk(0,    0,  0, 0, 0, 1, 0)});
        vt.push_back('{1, 1,     mk(1,    0,  0, 0, 1, 1, 0)});
        vt.push_back('{0, 2,     mk(1,    0,  0, 0, 1, 0, 0)});
        vt.push_back('{0, 3,     mk(1,    0,  0, 0, 1, 1, 0)});
        vt.push_back('{1, 799,   mk(799,  0,  0, 0, 1, 1, 0)});
        vt.push_back('{1, 800,   mk(800,  0,  0, 0, 0, 1, 0)});
        vt.push_back('{1, 856,   mk(856,  0,  1, 0, 0, 1, 0)});
        vt.push_back('{1, 976,   mk(976,  0,  0, 0, 0, 1, 0)});
        vt.push_back('{1, 1039,  mk(1039, 0,  0, 0, 0, 1, 0)});
        vt.push_back('{1, 1040,  mk(0,    1,  0, 0, 1, 1, 0)});
        vt.push_back('{0, 1598,  mk(799,  0,  0, 0, 1, 0, 0)});
        vt.push_back('{0, 1600,  mk(800,  0,  0, 0, 0, 0, 0)});
        vt.push_back('{0, 1710,  mk(855,  0,  0, 0, 0, 0, 0)});
        vt.push_back('{0, 1712,  mk(856,  0,  1, 0, 0, 0, 0)});
        vt.push_back('{0, 1950,  mk(975,  0,  1, 0, 0, 0, 0)});
        vt.push_back('{0, 1952,  mk(976,  0,  0, 0, 0, 0, 0)});
        vt.push_back('{0, 2078,  mk(1039, 0,  0, 0, 0, 0, 0)});
        vt.push_back('{0, 2080,  mk(0,    1,  0, 0, 1, 0, 0)});
        vt.push_back('{0, 22878, mk(1039, 10, 0, 0, 0, 0, 0)});
        vt.push_back('{0, 22880, mk(0,    11, 0, 0, 1, 0, 0)});

        repeat (5) @(negedge clk);
        chk_en = 1'b1;

        foreach (vt[i]) begin
            int guard;
            if (vt[i].n > 0 && rst_a) begin
                #2;
                rst_a = 1'b0;
                rst_s = 1'b0;
            end
            guard = 0;
            while (n_a < vt[i].n && guard < 30000) begin
                @(negedge clk);
                guard++;
            end
            if (n_a != vt[i].n) chk_int($sformatf("vec%0d_reach", i), n_a, vt[i].n);
            else check($sformatf("vec%0d", i), (vt[i].sel == 0) ? obs_a : obs_1, vt[i].exp);
        end

        for (int it = 0; it < 12; it++) begin
            int unsigned run, which, hold, dly;
            run   = $urandom_range(1500, 50);
            which = $urandom_range(3, 1);
            hold  = $urandom_range(4, 1);
            dly   = $urandom_range(4, 1);
            repeat (run) @(negedge clk);
            #(dly);
            if (which[0]) rst_a = 1'b1;
            if (which[1]) rst_s = 1'b1;
            repeat (hold) @(negedge clk);
            #2;
            rst_a = 1'b0;
            rst_s = 1'b0;
        end

        // Small raster: one full frame between consecutive frame_start pulses.
        ok = 1'b0;
        for (int k = 0; k < 2200; k++) begin
            @(negedge clk);
            if (obs_s.fs) begin ok = 1'b1; break; end
        end
        chk_int("fs_s_seen", ok, 1);
        per = 0; vs_cnt = 0; hs_cnt = 0; vo_cnt = 0; fs_after = 1'b1;
        for (int k = 0; k < 2200; k++) begin
            @(negedge clk);
            per++;
            if (k == 0) fs_after = obs_s.fs;
            if (obs_s.vs == 1'b1) vs_cnt++;
            if (obs_s.hs == 1'b0) hs_cnt++;
            if (obs_s.vo)         vo_cnt++;
            if (obs_s.fs) break;
        end
        chk_int("fs_s_width", fs_after, 0);
        chk_int("frame_s_period", per, 2016);
        chk_int("vsync_s_clks", vs_cnt, 288);
        chk_int("hsync_s_clks", hs_cnt, 252);
        chk_int("video_s_clks", vo_cnt, 720);

        // Asynchronous reset mid-frame on the small raster at (10,5).
        ok = 1'b0;
        for (int k = 0; k < 2200; k++) begin
            @(negedge clk);
            if (obs_s.h == 16'd10 && obs_s.v == 16'd5) begin ok = 1'b1; break; end
        end
        chk_int("mid_s_reach", ok, 1);
        #2 rst_s = 1'b1;
        #1 check("mid_s_reset", obs_s, mk(0, 0, 1, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        #2 rst_s = 1'b0;
        fs_cnt = 0;
        repeat (200) begin @(negedge clk); if (obs_s.fs) fs_cnt++; end
        chk_int("mid_s_no_fs", fs_cnt, 0);

        // Asynchronous reset mid-frame on the default raster at (500,2).
        pulse_reset(1'b1, 1'b0, 2);
        ok = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (obs_a.h == 16'd500 && obs_a.v == 16'd2) begin ok = 1'b1; break; end
        end
        chk_int("mid_a_reach", ok, 1);
        #2 rst_a = 1'b1;
        #1 check("mid_a_reset", obs_a, mk(0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        #2 rst_a = 1'b0;
        fs_cnt = 0;
        repeat (200) begin @(negedge clk); if (obs_a.fs || obs_1.fs) fs_cnt++; end
        chk_int("mid_a_no_fs", fs_cnt, 0);

        // Line period in clocks for CLK_DIV=2 and CLK_DIV=1.
        pulse_reset(1'b1, 1'b0, 2);
        t_a = -1; t_1 = -1;
        for (int k = 1; k <= 2200; k++) begin
            @(negedge clk);
            if (t_a < 0 && obs_a.h == 16'd0 && obs_a.v == 16'd1) t_a = k;
            if (t_1 < 0 && obs_1.h == 16'd0 && obs_1.v == 16'd1) t_1 = k;
        end
        chk_int("line_a_clks", t_a, 2080);
        chk_int("line_1_clks", t_1, 1040);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
